step_btn_debounce: RTL

//  Front-end conditioning stage feeding the sequence-detector top: turns a raw, bouncing

---
 rtl/step_btn_debounce_pkg.sv | 21 ++
 rtl/step_btn_debounce_if.sv | 21 ++
 rtl/step_btn_debounce_sync.sv | 21 ++
 rtl/step_btn_debounce.sv | 121 ++++++++++++
 4 files changed

// File: rtl/step_btn_debounce_pkg.sv
// Shared definitions for the button front end: FSM state encoding and counter sizing.
package seq_io_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    // One counter width covers debounce and both repeat intervals.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/step_btn_debounce_if.sv
// Board-pin side and detector side of the button/switch conditioning stage.
interface step_btn_debounce_if;
    import seq_io_pkg::*;

    logic               btn_raw;
    logic               sw_raw;
    logic               next_pulse;
    logic               in_sync;
    logic [STATE_W-1:0] btn_state;

    modport master (
        output btn_raw, sw_raw,
        input  next_pulse, in_sync, btn_state
    );

    modport slave (
        input  btn_raw, sw_raw,
        output next_pulse, in_sync, btn_state
    );

endinterface

// File: rtl/step_btn_debounce_sync.sv
// Two-flop synchroniser for one asynchronous pin, async active-low reset.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/step_btn_debounce.sv
// Debounces btn_raw into a single-cycle next_pulse and synchronises sw_raw.
// Optional auto-repeat while held: define AUTO_REPEAT_EN.
module step_btn_debounce
    import seq_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 12500000,
    parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)
) (
    input  logic               clk,
    input  logic               reset,
    step_btn_debounce_if.slave io
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             btn_s;
    logic             sw_s;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;

    sync_2ff u_sync_btn (.clk(clk), .reset(reset), .d(io.btn_raw), .q(btn_s));
    sync_2ff u_sync_sw  (.clk(clk), .reset(reset), .d(io.sw_raw),  .q(sw_s));

`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_DLY = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] REP_PER = CNT_W'(REPEAT_PERIOD);

    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic             armed_q, armed_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rcnt_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            rcnt_q  <= rcnt_d;
            armed_q <= armed_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
`ifdef AUTO_REPEAT_EN
        rcnt_d  = rcnt_q;
        armed_d = armed_q;
`endif
        case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = IDLE;
                end else if (cnt_q == DB_LAST) begin
                    state_d = HELD;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
`ifdef AUTO_REPEAT_EN
                // First repeat after REPEAT_DELAY, later ones every REPEAT_PERIOD.
                else if (rcnt_q == (armed_q ? REP_PER : REP_DLY)) begin
                    pulse_d = 1'b1;
                    rcnt_d  = CNT_W'(1);
                    armed_d = 1'b1;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
`endif
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_d = HELD;
                end else if (cnt_q == DB_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef AUTO_REPEAT_EN
        if (state_d == HELD && state_q != HELD) begin
            rcnt_d  = '0;
            armed_d = 1'b0;
        end
`endif
    end

    assign io.next_pulse = pulse_q;
    assign io.in_sync    = sw_s;
    assign io.btn_state  = state_q;

endmodule
